// File: rtl/rob_alloc_commit.sv
// In-order reorder buffer: 4-wide allocation at the tail, two completion ports,
// branch resolution with mispredict truncation, and up to 4 in-order retires per cycle.
module rob_alloc_commit #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDXW  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_en,
    input  logic [3:0]          inst_val_in,
    input  logic [63:0]         rcvr_pc_in,
    input  logic [3:0]          str_en_in,
    input  logic [3:0]          spec_brch_in,
    input  logic [3:0]          brch_pred_res_in,
    input  logic [3:0]          no_exe_in,
    input  logic [1:0]          cmpl_en,
    input  logic [2*IDXW-1:0]   cmpl_idx,
    input  logic                brch_rslv_en,
    input  logic [IDXW-1:0]     brch_rslv_idx,
    input  logic                brch_taken,
    output logic                alloc_rdy,
    output logic [IDXW-1:0]     alloc_base_idx,
    output logic [3:0]          cmt_val,
    output logic [3:0]          cmt_str,
    output logic                flush_out,
    output logic [15:0]         flush_pc,
    output logic                rob_empty
);

    logic [IDXW:0]      head_q, head_d;
    logic [IDXW:0]      tail_q, tail_d;
    logic [DEPTH-1:0]   alloc_q, alloc_d;
    logic [DEPTH-1:0]   done_q, done_d;
    logic [DEPTH-1:0]   val_q, str_q, spec_q, pred_q;
    logic [15:0]        pc_q [DEPTH];
    logic [3:0]         cmt_val_q, cmt_val_d;
    logic [3:0]         cmt_str_q, cmt_str_d;
    logic               flush_q, flush_d;
    logic [15:0]        flush_pc_q, flush_pc_d;

    logic [IDXW:0]      count;
    logic [IDXW+1:0]    free_cnt;
    logic               mispredict_now;
    logic               alloc_fire;
    logic [IDXW-1:0]    rslv_off;
    logic [IDXW:0]      rslv_ptr;
    logic [IDXW-1:0]    widx;
    logic [2:0]         n_ret;
    logic               stop;

    assign count          = tail_q - head_q;
    assign free_cnt       = (IDXW+2)'(DEPTH) - (IDXW+2)'(count);
    assign mispredict_now = brch_rslv_en & alloc_q[brch_rslv_idx] & spec_q[brch_rslv_idx]
                            & (brch_taken != pred_q[brch_rslv_idx]);
    assign alloc_rdy      = (free_cnt >= (IDXW+2)'(4)) & ~mispredict_now;
    assign alloc_fire     = alloc_en & alloc_rdy;
    // Branch distance from head rebuilds its full pointer, wrap bit included.
    assign rslv_off       = brch_rslv_idx - head_q[IDXW-1:0];
    assign rslv_ptr       = head_q + (IDXW+1)'(rslv_off);

    assign alloc_base_idx = tail_q[IDXW-1:0];
    assign cmt_val        = cmt_val_q;
    assign cmt_str        = cmt_str_q;
    assign flush_out      = flush_q;
    assign flush_pc       = flush_pc_q;
    assign rob_empty      = (head_q == tail_q);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        alloc_d    = alloc_q;
        done_d     = done_q;
        cmt_val_d  = '0;
        cmt_str_d  = '0;
        flush_d    = 1'b0;
        flush_pc_d = flush_pc_q;
        widx       = '0;
        n_ret      = '0;
        stop       = 1'b0;

        for (int unsigned p = 0; p < 2; p++) begin
            if (cmpl_en[p] && alloc_q[cmpl_idx[IDXW*p +: IDXW]])
                done_d[cmpl_idx[IDXW*p +: IDXW]] = 1'b1;
        end
        if (brch_rslv_en && alloc_q[brch_rslv_idx])
            done_d[brch_rslv_idx] = 1'b1;

        // Commit looks only at pre-edge done, so a same-edge completion waits a cycle.
        for (int unsigned k = 0; k < 4; k++) begin
            widx = head_q[IDXW-1:0] + IDXW'(k);
            if (!stop && ((IDXW+1)'(k) < count) && alloc_q[widx] && done_q[widx]) begin
                cmt_val_d[k]  = val_q[widx];
                cmt_str_d[k]  = val_q[widx] & str_q[widx];
                alloc_d[widx] = 1'b0;
                done_d[widx]  = 1'b0;
                n_ret         = n_ret + 3'd1;
            end else begin
                stop = 1'b1;
            end
        end
        head_d = head_q + (IDXW+1)'(n_ret);

        if (alloc_fire) begin
            for (int unsigned i = 0; i < 4; i++) begin
                widx          = tail_q[IDXW-1:0] + IDXW'(i);
                alloc_d[widx] = 1'b1;
                done_d[widx]  = ~inst_val_in[i] | no_exe_in[i];
            end
            tail_d = tail_q + (IDXW+1)'(4);
        end

        // Truncation is applied last so it overrides completions to younger entries.
        if (mispredict_now) begin
            tail_d     = rslv_ptr + (IDXW+1)'(1);
            flush_d    = 1'b1;
            flush_pc_d = pc_q[brch_rslv_idx];
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if ((IDXW'(j) - head_q[IDXW-1:0]) > rslv_off) begin
                    alloc_d[j] = 1'b0;
                    done_d[j]  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            alloc_q    <= '0;
            done_q     <= '0;
            cmt_val_q  <= '0;
            cmt_str_q  <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            alloc_q    <= alloc_d;
            done_q     <= done_d;
            cmt_val_q  <= cmt_val_d;
            cmt_str_q  <= cmt_str_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    // Payload is qualified by alloc_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && alloc_fire) begin
            for (int unsigned i = 0; i < 4; i++) begin
                val_q [tail_q[IDXW-1:0] + IDXW'(i)] <= inst_val_in[i];
                str_q [tail_q[IDXW-1:0] + IDXW'(i)] <= str_en_in[i];
                spec_q[tail_q[IDXW-1:0] + IDXW'(i)] <= spec_brch_in[i];
                pred_q[tail_q[IDXW-1:0] + IDXW'(i)] <= brch_pred_res_in[i];
                pc_q  [tail_q[IDXW-1:0] + IDXW'(i)] <= rcvr_pc_in[16*i +: 16];
            end
        end
    end

endmodule

// File: tb/tb_rob_alloc_commit.sv
// Directed bench for rob_alloc_commit: one task per scenario, hand-computed expectations.
module tb_rob_alloc_commit;

    logic        clk;
    logic        rst;
    logic        alloc_en;
    logic [3:0]  inst_val_in;
    logic [63:0] rcvr_pc_in;
    logic [3:0]  str_en_in;
    logic [3:0]  spec_brch_in;
    logic [3:0]  brch_pred_res_in;
    logic [3:0]  no_exe_in;
    logic [1:0]  cmpl_en;
    logic [7:0]  cmpl_idx;
    logic        brch_rslv_en;
    logic [3:0]  brch_rslv_idx;
    logic        brch_taken;
    logic        alloc_rdy;
    logic [3:0]  alloc_base_idx;
    logic [3:0]  cmt_val;
    logic [3:0]  cmt_str;
    logic        flush_out;
    logic [15:0] flush_pc;
    logic        rob_empty;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    rob_alloc_commit #(.DEPTH(16), .IDXW(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_en         (alloc_en),
        .inst_val_in      (inst_val_in),
        .rcvr_pc_in       (rcvr_pc_in),
        .str_en_in        (str_en_in),
        .spec_brch_in     (spec_brch_in),
        .brch_pred_res_in (brch_pred_res_in),
        .no_exe_in        (no_exe_in),
        .cmpl_en          (cmpl_en),
        .cmpl_idx         (cmpl_idx),
        .brch_rslv_en     (brch_rslv_en),
        .brch_rslv_idx    (brch_rslv_idx),
        .brch_taken       (brch_taken),
        .alloc_rdy        (alloc_rdy),
        .alloc_base_idx   (alloc_base_idx),
        .cmt_val          (cmt_val),
        .cmt_str          (cmt_str),
        .flush_out        (flush_out),
        .flush_pc         (flush_pc),
        .rob_empty        (rob_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alloc_en         = 1'b0;
        inst_val_in      = 4'h0;
        rcvr_pc_in       = 64'h0;
        str_en_in        = 4'h0;
        spec_brch_in     = 4'h0;
        brch_pred_res_in = 4'h0;
        no_exe_in        = 4'h0;
        cmpl_en          = 2'b00;
        cmpl_idx         = 8'h00;
        brch_rslv_en     = 1'b0;
        brch_rslv_idx    = 4'h0;
        brch_taken       = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt += 7;
        if (alloc_rdy !== 1'b1) $display("FAIL rst_alloc_rdy: got %b want 1", alloc_rdy); else pass_cnt++;
        if (alloc_base_idx !== 4'h0) $display("FAIL rst_base: got %h want 0", alloc_base_idx); else pass_cnt++;
        if (cmt_val !== 4'h0) $display("FAIL rst_cmt_val: got %b want 0000", cmt_val); else pass_cnt++;
        if (cmt_str !== 4'h0) $display("FAIL rst_cmt_str: got %b want 0000", cmt_str); else pass_cnt++;
        if (flush_out !== 1'b0) $display("FAIL rst_flush: got %b want 0", flush_out); else pass_cnt++;
        if (flush_pc !== 16'h0) $display("FAIL rst_flush_pc: got %h want 0000", flush_pc); else pass_cnt++;
        if (rob_empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", rob_empty); else pass_cnt++;
    endtask

    task automatic test_no_exe_commit();
        do_reset();
        alloc_en = 1'b1; inst_val_in = 4'hF; no_exe_in = 4'hF; str_en_in = 4'b0101;
        tick();
        clear_inputs();
        total_cnt += 3;
        if (rob_empty !== 1'b0) $display("FAIL noexe_empty_after_alloc: got %b want 0", rob_empty); else pass_cnt++;
        if (cmt_val !== 4'h0) $display("FAIL noexe_early_cmt: got %b want 0000", cmt_val); else pass_cnt++;
        if (alloc_base_idx !== 4'h4) $display("FAIL noexe_base: got %h want 4", alloc_base_idx); else pass_cnt++;
        tick();
        total_cnt += 3;
        if (cmt_val !== 4'b1111) $display("FAIL noexe_cmt_val: got %b want 1111", cmt_val); else pass_cnt++;
        if (cmt_str !== 4'b0101) $display("FAIL noexe_cmt_str: got %b want 0101", cmt_str); else pass_cnt++;
        if (rob_empty !== 1'b1) $display("FAIL noexe_empty: got %b want 1", rob_empty); else pass_cnt++;
        // entries 4..7: slot2 invalid (done at alloc, silent), slot3 needs execution
        alloc_en = 1'b1; inst_val_in = 4'b1011; no_exe_in = 4'b0011; str_en_in = 4'b0110;
        tick();
        clear_inputs();
        tick();
        total_cnt += 3;
        if (cmt_val !== 4'b0011) $display("FAIL inval_cmt_val: got %b want 0011", cmt_val); else pass_cnt++;
        if (cmt_str !== 4'b0010) $display("FAIL inval_cmt_str: got %b want 0010", cmt_str); else pass_cnt++;
        if (rob_empty !== 1'b0) $display("FAIL inval_empty: got %b want 0", rob_empty); else pass_cnt++;
        cmpl_en = 2'b01; cmpl_idx = 8'h07;
        tick();
        clear_inputs();
        tick();
        total_cnt += 2;
        if (cmt_val !== 4'b0001) $display("FAIL inval_last_cmt: got %b want 0001", cmt_val); else pass_cnt++;
        if (rob_empty !== 1'b1) $display("FAIL inval_last_empty: got %b want 1", rob_empty); else pass_cnt++;
    endtask

    task automatic test_full();
        do_reset();
        for (int r = 0; r < 4; r++) begin
            alloc_en = 1'b1; inst_val_in = 4'hF; no_exe_in = 4'h0;
            #1;
            total_cnt++;
            if (alloc_rdy !== 1'b1) $display("FAIL full_rdy_round%0d: got %b want 1", r, alloc_rdy); else pass_cnt++;
            tick();
        end
        total_cnt += 3;
        if (alloc_rdy !== 1'b0) $display("FAIL full_rdy: got %b want 0", alloc_rdy); else pass_cnt++;
        if (alloc_base_idx !== 4'h0) $display("FAIL full_base: got %h want 0", alloc_base_idx); else pass_cnt++;
        if (rob_empty !== 1'b0) $display("FAIL full_empty: got %b want 0", rob_empty); else pass_cnt++;
        tick();
        clear_inputs();
        total_cnt++;
        if (alloc_base_idx !== 4'h0) $display("FAIL full_ignored_alloc: got %h want 0", alloc_base_idx); else pass_cnt++;
        cmpl_en = 2'b01; cmpl_idx = 8'h00;
        tick();
        clear_inputs();
        total_cnt++;
        if (cmt_val !== 4'h0) $display("FAIL full_cmt_latency: got %b want 0000", cmt_val); else pass_cnt++;
        tick();
        total_cnt += 2;
        if (cmt_val !== 4'b0001) $display("FAIL full_cmt1: got %b want 0001", cmt_val); else pass_cnt++;
        if (alloc_rdy !== 1'b0) $display("FAIL full_rdy_15: got %b want 0", alloc_rdy); else pass_cnt++;
        cmpl_en = 2'b11; cmpl_idx = 8'h21;
        tick();
        clear_inputs();
        tick();
        total_cnt += 2;
        if (cmt_val !== 4'b0011) $display("FAIL full_cmt2: got %b want 0011", cmt_val); else pass_cnt++;
        if (alloc_rdy !== 1'b0) $display("FAIL full_rdy_13: got %b want 0", alloc_rdy); else pass_cnt++;
        cmpl_en = 2'b11; cmpl_idx = 8'h33;
        tick();
        clear_inputs();
        tick();
        total_cnt += 2;
        if (cmt_val !== 4'b0001) $display("FAIL full_cmt_dup: got %b want 0001", cmt_val); else pass_cnt++;
        if (alloc_rdy !== 1'b1) $display("FAIL full_rdy_12: got %b want 1", alloc_rdy); else pass_cnt++;
    endtask

    task automatic test_out_of_order();
        do_reset();
        alloc_en = 1'b1; inst_val_in = 4'hF; no_exe_in = 4'h0; str_en_in = 4'b0010;
        tick();
        clear_inputs();
        cmpl_en = 2'b01; cmpl_idx = 8'h02;
        tick();
        total_cnt++;
        if (cmt_val !== 4'h0) $display("FAIL ooo_after2: got %b want 0000", cmt_val); else pass_cnt++;
        cmpl_idx = 8'h03;
        tick();
        total_cnt++;
        if (cmt_val !== 4'h0) $display("FAIL ooo_after3: got %b want 0000", cmt_val); else pass_cnt++;
        cmpl_idx = 8'h00;
        tick();
        clear_inputs();
        total_cnt++;
        if (cmt_val !== 4'h0) $display("FAIL ooo_after0_same: got %b want 0000", cmt_val); else pass_cnt++;
        tick();
        total_cnt++;
        if (cmt_val !== 4'b0001) $display("FAIL ooo_cmt0: got %b want 0001", cmt_val); else pass_cnt++;
        cmpl_en = 2'b10; cmpl_idx = 8'h10;
        tick();
        clear_inputs();
        total_cnt++;
        if (cmt_val !== 4'h0) $display("FAIL ooo_after1_same: got %b want 0000", cmt_val); else pass_cnt++;
        tick();
        total_cnt += 3;
        if (cmt_val !== 4'b0111) $display("FAIL ooo_cmt123: got %b want 0111", cmt_val); else pass_cnt++;
        if (cmt_str !== 4'b0001) $display("FAIL ooo_str: got %b want 0001", cmt_str); else pass_cnt++;
        if (rob_empty !== 1'b1) $display("FAIL ooo_empty: got %b want 1", rob_empty); else pass_cnt++;
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc_en = 1'b1; inst_val_in = 4'hF; no_exe_in = 4'b1101;
        spec_brch_in = 4'b0010; brch_pred_res_in = 4'b0000;
        rcvr_pc_in = 64'h1333_1222_0040_1000;
        tick();
        clear_inputs();
        brch_rslv_en = 1'b1; brch_rslv_idx = 4'h1; brch_taken = 1'b1;
        cmpl_en = 2'b01; cmpl_idx = 8'h03;
        #1;
        total_cnt++;
        if (alloc_rdy !== 1'b0) $display("FAIL mp_rdy_low: got %b want 0", alloc_rdy); else pass_cnt++;
        tick();
        clear_inputs();
        total_cnt += 4;
        if (flush_out !== 1'b1) $display("FAIL mp_flush: got %b want 1", flush_out); else pass_cnt++;
        if (flush_pc !== 16'h0040) $display("FAIL mp_flush_pc: got %h want 0040", flush_pc); else pass_cnt++;
        if (alloc_base_idx !== 4'h2) $display("FAIL mp_tail: got %h want 2", alloc_base_idx); else pass_cnt++;
        if (cmt_val !== 4'b0001) $display("FAIL mp_cmt0: got %b want 0001", cmt_val); else pass_cnt++;
        tick();
        total_cnt += 3;
        if (flush_out !== 1'b0) $display("FAIL mp_flush_pulse: got %b want 0", flush_out); else pass_cnt++;
        if (cmt_val !== 4'b0001) $display("FAIL mp_cmt_branch: got %b want 0001", cmt_val); else pass_cnt++;
        if (rob_empty !== 1'b1) $display("FAIL mp_empty: got %b want 1", rob_empty); else pass_cnt++;
        tick();
        total_cnt++;
        if (cmt_val !== 4'h0) $display("FAIL mp_no_younger: got %b want 0000", cmt_val); else pass_cnt++;
        // correctly predicted branch at entry 2: no flush
        alloc_en = 1'b1; inst_val_in = 4'hF; no_exe_in = 4'b1110;
        spec_brch_in = 4'b0001; brch_pred_res_in = 4'b0001;
        tick();
        clear_inputs();
        brch_rslv_en = 1'b1; brch_rslv_idx = 4'h2; brch_taken = 1'b1;
        #1;
        total_cnt++;
        if (alloc_rdy !== 1'b1) $display("FAIL okbr_rdy: got %b want 1", alloc_rdy); else pass_cnt++;
        tick();
        clear_inputs();
        total_cnt += 2;
        if (flush_out !== 1'b0) $display("FAIL okbr_flush: got %b want 0", flush_out); else pass_cnt++;
        if (cmt_val !== 4'h0) $display("FAIL okbr_cmt_early: got %b want 0000", cmt_val); else pass_cnt++;
        tick();
        total_cnt += 2;
        if (cmt_val !== 4'b1111) $display("FAIL okbr_cmt: got %b want 1111", cmt_val); else pass_cnt++;
        if (alloc_base_idx !== 4'h6) $display("FAIL okbr_base: got %h want 6", alloc_base_idx); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [3:0] exp_base;
        do_reset();
        for (int r = 0; r < 10; r++) begin
            exp_base = 4'(4 * r);
            total_cnt++;
            if (alloc_base_idx !== exp_base) $display("FAIL wrap_base_r%0d: got %h want %h", r, alloc_base_idx, exp_base); else pass_cnt++;
            alloc_en = 1'b1; inst_val_in = 4'hF; no_exe_in = 4'hF;
            tick();
            clear_inputs();
            tick();
            total_cnt++;
            if (cmt_val !== 4'b1111) $display("FAIL wrap_cmt_r%0d: got %b want 1111", r, cmt_val); else pass_cnt++;
        end
        total_cnt += 2;
        if (rob_empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", rob_empty); else pass_cnt++;
        if (alloc_base_idx !== 4'h8) $display("FAIL wrap_final_base: got %h want 8", alloc_base_idx); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        alloc_en = 1'b1; inst_val_in = 4'hF; no_exe_in = 4'h0;
        spec_brch_in = 4'b0010; brch_pred_res_in = 4'b0000;
        tick();
        spec_brch_in = 4'b0000;
        cmpl_en = 2'b01; cmpl_idx = 8'h00;
        tick();
        clear_inputs();
        total_cnt++;
        if (alloc_base_idx !== 4'h8) $display("FAIL mrst_pre_base: got %h want 8", alloc_base_idx); else pass_cnt++;
        rst = 1'b1;
        brch_rslv_en = 1'b1; brch_rslv_idx = 4'h1; brch_taken = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        total_cnt += 5;
        if (rob_empty !== 1'b1) $display("FAIL mrst_empty: got %b want 1", rob_empty); else pass_cnt++;
        if (cmt_val !== 4'h0) $display("FAIL mrst_cmt: got %b want 0000", cmt_val); else pass_cnt++;
        if (flush_out !== 1'b0) $display("FAIL mrst_flush: got %b want 0", flush_out); else pass_cnt++;
        if (alloc_base_idx !== 4'h0) $display("FAIL mrst_base: got %h want 0", alloc_base_idx); else pass_cnt++;
        if (alloc_rdy !== 1'b1) $display("FAIL mrst_rdy: got %b want 1", alloc_rdy); else pass_cnt++;
        tick();
        total_cnt += 2;
        if (cmt_val !== 4'h0) $display("FAIL mrst_cmt_after: got %b want 0000", cmt_val); else pass_cnt++;
        if (flush_out !== 1'b0) $display("FAIL mrst_flush_after: got %b want 0", flush_out); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_no_exe_commit();
        test_full();
        test_out_of_order();
        test_mispredict();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
